// File: rtl/ddr3_phy_pkg.sv
// ddr3_phy_pkg
//   Shared types and defaults for the DDR3 PHY receive-lane logic.
//   - align_state_e   : lane-alignment FSM states
//   - DEF_DATA_WIDTH  : default deserialization ratio
//   - DEF_TRAIN_PATTERN : default aligned training word
package ddr3_phy_pkg;

  localparam int          DEF_DATA_WIDTH    = 4;
  localparam logic [3:0]  DEF_TRAIN_PATTERN = 4'b1010;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    CHECK,
    SLIP_OR_MOVE,
    DONE,
    FAIL
  } align_state_e;

endpackage

// File: rtl/ddr3_rx_pulse_settle.sv
// ddr3_rx_pulse_settle
//   One-cycle pulse generator for the LOAD / SLIP / MOVE requests of the
//   alignment FSM, plus the settle down-counter that every pulse restarts.
//   Ports:
//     gclk, grst_n            : clock, async active-low reset
//     fire_load/slip/move     : one-cycle requests from the FSM
//     load/slip/move_pulse    : mutually exclusive pulses to the IOD
//     settle_done             : high in the last cycle of the settle window
//     after_move              : most recent pulse was a MOVE
module ddr3_rx_pulse_settle #(
  parameter int SETTLE_CYC = 4
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic fire_load,
  input  logic fire_slip,
  input  logic fire_move,
  output logic load_pulse,
  output logic slip_pulse,
  output logic move_pulse,
  output logic settle_done,
  output logic after_move
);

  localparam int CW = 4;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          after_move_q, after_move_d;
  logic          any_fire;

  always_comb begin
    // fixed priority keeps the three pulses exclusive even if the FSM misbehaves
    load_pulse   = fire_load;
    slip_pulse   = fire_slip & ~fire_load;
    move_pulse   = fire_move & ~fire_load & ~fire_slip;
    any_fire     = fire_load | fire_slip | fire_move;
    cnt_d        = cnt_q;
    after_move_d = after_move_q;
    if (any_fire) begin
      cnt_d        = CW'(SETTLE_CYC);
      after_move_d = move_pulse;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      cnt_q        <= '0;
      after_move_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      after_move_q <= after_move_d;
    end
  end

  assign settle_done = (cnt_q == CW'(1));
  assign after_move  = after_move_q;

endmodule

// File: rtl/ddr3_rx_lane_align.sv
// ddr3_rx_lane_align
//   Per-lane read-capture word alignment. Trains the IOD bit-slip and delay
//   line until RX_DATA_0 shows TRAIN_PATTERN for MATCH_CNT consecutive words.
//   Ports:
//     FAB_CLK, ARST_N            : clock, async active-low reset
//     START                      : training request (ignored while BUSY)
//     RX_DATA_0                  : deserialized word from IOD
//     DELAY_LINE_OUT_OF_RANGE_0  : IOD delay limit flag
//     RX_BIT_SLIP_0, DELAY_LINE_MOVE_0/DIRECTION_0/LOAD_0 : IOD controls
//     BUSY, ALIGN_DONE, ALIGN_FAIL, TAP_CNT : status
//     RX_DATA_OUT                : RX_DATA_0 delayed one cycle
//   Optional (DDR3_RX_ALIGN_MONITOR_EN): ERR_CNT, LOCK_LOST post-lock monitor.
module ddr3_rx_lane_align
  import ddr3_phy_pkg::*;
#(
  parameter int                    DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = DATA_WIDTH'(DEF_TRAIN_PATTERN),
  parameter int                    MATCH_CNT     = 8,
  parameter int                    SETTLE_CYC    = 4,
  parameter int                    MAX_TAPS      = 128
) (
  input  logic                  FAB_CLK,
  input  logic                  ARST_N,
  input  logic                  START,
  input  logic [DATA_WIDTH-1:0] RX_DATA_0,
  input  logic                  DELAY_LINE_OUT_OF_RANGE_0,
  output logic                  RX_BIT_SLIP_0,
  output logic                  DELAY_LINE_MOVE_0,
  output logic                  DELAY_LINE_DIRECTION_0,
  output logic                  DELAY_LINE_LOAD_0,
  output logic                  BUSY,
  output logic                  ALIGN_DONE,
  output logic                  ALIGN_FAIL,
  output logic [7:0]            TAP_CNT,
  output logic [DATA_WIDTH-1:0] RX_DATA_OUT
`ifdef DDR3_RX_ALIGN_MONITOR_EN
  ,
  output logic [15:0]           ERR_CNT,
  output logic                  LOCK_LOST
`endif
);

  align_state_e          state_q, state_d;
  logic [7:0]            tap_cnt_q, tap_cnt_d;
  logic [7:0]            slip_cnt_q, slip_cnt_d;
  logic [7:0]            match_cnt_q, match_cnt_d;
  logic [DATA_WIDTH-1:0] rx_data_q;
  logic                  fire_load, fire_slip, fire_move;
  logic                  settle_done, after_move;
  logic                  busy, start_acc, word_ok;

  assign busy      = (state_q != IDLE) && (state_q != DONE) && (state_q != FAIL);
  assign start_acc = START && !busy;
  assign word_ok   = (RX_DATA_0 == TRAIN_PATTERN);

  always_comb begin
    state_d     = state_q;
    tap_cnt_d   = tap_cnt_q;
    slip_cnt_d  = slip_cnt_q;
    match_cnt_d = match_cnt_q;
    fire_load   = 1'b0;
    fire_slip   = 1'b0;
    fire_move   = 1'b0;
    unique case (state_q)
      IDLE, DONE, FAIL: if (START) state_d = LOAD;
      LOAD: begin
        fire_load  = 1'b1;
        tap_cnt_d  = '0;
        slip_cnt_d = '0;
        state_d    = SETTLE;
      end
      SETTLE: begin
        match_cnt_d = '0;
        // a delay line pushed past its limit cannot be trusted even if data looks good
        if (after_move && DELAY_LINE_OUT_OF_RANGE_0) state_d = FAIL;
        else if (settle_done)                        state_d = CHECK;
      end
      CHECK: begin
        if (word_ok) begin
          if (match_cnt_q == 8'(MATCH_CNT - 1)) state_d = DONE;
          else match_cnt_d = match_cnt_q + 8'd1;
        end else if (match_cnt_q == '0) begin
          state_d = SLIP_OR_MOVE;
        end else begin
          // a broken run gets one fresh attempt at this setting
          match_cnt_d = '0;
        end
      end
      SLIP_OR_MOVE: begin
        if (slip_cnt_q < 8'(DATA_WIDTH - 1)) begin
          fire_slip  = 1'b1;
          slip_cnt_d = slip_cnt_q + 8'd1;
          state_d    = SETTLE;
        end else begin
          slip_cnt_d = '0;
          if (tap_cnt_q == 8'(MAX_TAPS - 1)) begin
            state_d = FAIL;
          end else begin
            fire_move = 1'b1;
            if (tap_cnt_q != 8'hFF) tap_cnt_d = tap_cnt_q + 8'd1;
            state_d = SETTLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state_q     <= IDLE;
      tap_cnt_q   <= '0;
      slip_cnt_q  <= '0;
      match_cnt_q <= '0;
      rx_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      tap_cnt_q   <= tap_cnt_d;
      slip_cnt_q  <= slip_cnt_d;
      match_cnt_q <= match_cnt_d;
      rx_data_q   <= RX_DATA_0;
    end
  end

  ddr3_rx_pulse_settle #(
    .SETTLE_CYC (SETTLE_CYC)
  ) u_pulse (
    .gclk        (FAB_CLK),
    .grst_n      (ARST_N),
    .fire_load   (fire_load),
    .fire_slip   (fire_slip),
    .fire_move   (fire_move),
    .load_pulse  (DELAY_LINE_LOAD_0),
    .slip_pulse  (RX_BIT_SLIP_0),
    .move_pulse  (DELAY_LINE_MOVE_0),
    .settle_done (settle_done),
    .after_move  (after_move)
  );

  // training only ever steps the delay upward
  assign DELAY_LINE_DIRECTION_0 = busy;
  assign BUSY                   = busy;
  assign ALIGN_DONE             = (state_q == DONE);
  assign ALIGN_FAIL             = (state_q == FAIL);
  assign TAP_CNT                = tap_cnt_q;
  assign RX_DATA_OUT            = rx_data_q;

`ifdef DDR3_RX_ALIGN_MONITOR_EN
  logic [15:0] err_cnt_q, err_cnt_d;
  logic        lock_lost_q, lock_lost_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (start_acc) err_cnt_d = '0;
    else if (state_q == DONE && !word_ok && err_cnt_q != 16'hFFFF)
      err_cnt_d = err_cnt_q + 16'd1;
    lock_lost_d = start_acc ? 1'b0 : (lock_lost_q | (err_cnt_d >= 16'd16));
  end

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      err_cnt_q   <= '0;
      lock_lost_q <= 1'b0;
    end else begin
      err_cnt_q   <= err_cnt_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign ERR_CNT   = err_cnt_q;
  assign LOCK_LOST = lock_lost_q;
`endif

endmodule

// File: tb/tb_ddr3_rx_lane_align.sv
// tb_ddr3_rx_lane_align
//   Randomized bench for ddr3_rx_lane_align. A behavioural IOD model reacts
//   to SLIP/MOVE/LOAD pulses; expected slip/move counts, final tap and
//   completion latency are derived arithmetically from the training rules.
//   Also exercises the DDR3_RX_ALIGN_MONITOR_EN outputs when that macro is set.
module tb_ddr3_rx_lane_align;

  localparam int         DW    = 4;
  localparam logic [3:0] PAT   = 4'b1010;
  localparam int         MATCH = 8;
  localparam int         SET   = 4;
  localparam int         MAXT  = 128;

  logic          FAB_CLK = 1'b0;
  logic          ARST_N  = 1'b0;
  logic          START   = 1'b0;
  logic [DW-1:0] RX_DATA_0 = '0;
  logic          DELAY_LINE_OUT_OF_RANGE_0 = 1'b0;
  logic          RX_BIT_SLIP_0, DELAY_LINE_MOVE_0, DELAY_LINE_DIRECTION_0, DELAY_LINE_LOAD_0;
  logic          BUSY, ALIGN_DONE, ALIGN_FAIL;
  logic [7:0]    TAP_CNT;
  logic [DW-1:0] RX_DATA_OUT;
`ifdef DDR3_RX_ALIGN_MONITOR_EN
  logic [15:0]   ERR_CNT;
  logic          LOCK_LOST;
`endif

  ddr3_rx_lane_align dut (
    .FAB_CLK                   (FAB_CLK),
    .ARST_N                    (ARST_N),
    .START                     (START),
    .RX_DATA_0                 (RX_DATA_0),
    .DELAY_LINE_OUT_OF_RANGE_0 (DELAY_LINE_OUT_OF_RANGE_0),
    .RX_BIT_SLIP_0             (RX_BIT_SLIP_0),
    .DELAY_LINE_MOVE_0         (DELAY_LINE_MOVE_0),
    .DELAY_LINE_DIRECTION_0    (DELAY_LINE_DIRECTION_0),
    .DELAY_LINE_LOAD_0         (DELAY_LINE_LOAD_0),
    .BUSY                      (BUSY),
    .ALIGN_DONE                (ALIGN_DONE),
    .ALIGN_FAIL                (ALIGN_FAIL),
    .TAP_CNT                   (TAP_CNT),
    .RX_DATA_OUT               (RX_DATA_OUT)
`ifdef DDR3_RX_ALIGN_MONITOR_EN
    ,
    .ERR_CNT                   (ERR_CNT),
    .LOCK_LOST                 (LOCK_LOST)
`endif
  );

  always #5 FAB_CLK = ~FAB_CLK;

  int checks = 0;
  int errors = 0;

  // IOD model state
  int         m_slips = 0, m_moves = 0, slip_base = 0;
  int         need_slip = 0, need_tap = 0, force_cnt = 0;
  bit         oor_en = 1'b0, direct_en = 1'b0;
  logic [3:0] bad_word = 4'b0000, direct_word = 4'b0000;
  // pulse bookkeeping
  int         n_slip = 0, n_move = 0, n_load = 0, n_multi = 0, n_dir_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // advance to the next falling edge, observe the IOD controls, then drive
  // the word the IOD would present for the following rising edge
  task automatic tick();
    int np;
    @(negedge FAB_CLK);
    np = int'(RX_BIT_SLIP_0) + int'(DELAY_LINE_MOVE_0) + int'(DELAY_LINE_LOAD_0);
    if (np > 1) n_multi++;
    if (BUSY !== DELAY_LINE_DIRECTION_0) n_dir_err++;
    if (RX_BIT_SLIP_0)     begin n_slip++; m_slips++; end
    if (DELAY_LINE_MOVE_0) begin n_move++; m_moves++; end
    if (DELAY_LINE_LOAD_0) begin n_load++; m_moves = 0; end
    if (direct_en) RX_DATA_0 = direct_word;
    else if (force_cnt > 0) begin RX_DATA_0 = bad_word; force_cnt--; end
    else RX_DATA_0 = ((((m_slips - slip_base) % 4) == need_slip) && (m_moves >= need_tap))
                     ? PAT : bad_word;
    DELAY_LINE_OUT_OF_RANGE_0 = oor_en && (m_moves >= 3);
  endtask

  // one training run; expectations come from the caller's arithmetic
  task automatic train(input string tag, input int e_slip, input int e_move,
                       input bit e_fail, input int e_cyc, input bit poke);
    int cyc, ldc, s0, m0, l0;
    s0 = n_slip; m0 = n_move; l0 = n_load; ldc = -1; cyc = 0;
    START = 1'b1;
    do begin
      tick();
      START = 1'b0;
      cyc++;
      if (DELAY_LINE_LOAD_0 && ldc < 0) ldc = cyc;
      if (poke && cyc == 10) START = 1'b1;  // must be ignored while busy
    end while (!(ALIGN_DONE || ALIGN_FAIL) && cyc < 5000);
    chk({tag, ".cyc"},   cyc, e_cyc);
    chk({tag, ".ldcyc"}, ldc, 1);
    chk({tag, ".loads"}, n_load - l0, 1);
    chk({tag, ".slips"}, n_slip - s0, e_slip);
    chk({tag, ".moves"}, n_move - m0, e_move);
    chk({tag, ".done"},  ALIGN_DONE, !e_fail);
    chk({tag, ".fail"},  ALIGN_FAIL, e_fail);
    chk({tag, ".busy"},  BUSY, 0);
    chk({tag, ".dir"},   DELAY_LINE_DIRECTION_0, 0);
    chk({tag, ".tap"},   TAP_CNT, e_move);
  endtask

  task automatic scen(input string tag, input int ns, input int nt, input bit oor, input bit poke);
    int es, em, ecyc;
    bit ef;
    need_slip = ns; need_tap = nt; oor_en = oor;
    slip_base = m_slips; m_moves = 0;
    bad_word = 4'($urandom_range(0, 15));
    if (bad_word == PAT) bad_word = 4'b0000;
    if (oor) begin
      // three full taps of failed settings, then one settle cycle after the 3rd move
      es = 9; em = 3; ef = 1'b1; ecyc = 2 + 12 * (SET + 2) + 1;
    end else if (nt >= MAXT) begin
      es = MAXT * 3; em = MAXT - 1; ef = 1'b1; ecyc = 2 + (es + em + 1) * (SET + 2);
    end else begin
      // each tap offers four slip phases; cumulative slips reach 3*nt at tap nt
      em = nt; es = 3 * nt + ((ns + nt) % 4); ef = 1'b0;
      ecyc = 2 + (es + em) * (SET + 2) + SET + MATCH;
    end
    train(tag, es, em, ef, ecyc, poke);
  endtask

  initial begin
    // reset state
    repeat (3) tick();
    chk("rst.busy", BUSY, 0);
    chk("rst.done", ALIGN_DONE, 0);
    chk("rst.fail", ALIGN_FAIL, 0);
    chk("rst.tap",  TAP_CNT, 0);
    chk("rst.pulses", {RX_BIT_SLIP_0, DELAY_LINE_MOVE_0, DELAY_LINE_LOAD_0, DELAY_LINE_DIRECTION_0}, 0);
    chk("rst.rxout", RX_DATA_OUT, 0);
    ARST_N = 1'b1;
    repeat (2) tick();

    // registered data path
    direct_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      logic [3:0] w;
      w = 4'($urandom_range(0, 15));
      direct_word = w;
      tick();
      tick();
      chk("rxout", RX_DATA_OUT, w);
    end
    direct_en = 1'b0;

    scen("aligned", 0, 0, 1'b0, 1'b0);
    scen("slip2",   2, 0, 1'b0, 1'b0);
    scen("tap5",    3, 5, 1'b0, 1'b0);
    scen("oor",     0, 1000, 1'b1, 1'b0);
    oor_en = 1'b0;
    for (int i = 0; i < 6; i++)
      scen("rand", int'($urandom_range(0, 3)), int'($urandom_range(0, 6)), 1'b0, (i % 2) == 1);
    scen("maxtap", 0, 1000, 1'b0, 1'b0);

    // reset in the middle of CHECK
    need_slip = 0; need_tap = 0; slip_base = m_slips; m_moves = 0;
    START = 1'b1;
    tick();
    START = 1'b0;
    repeat (7) tick();
    #1 ARST_N = 1'b0;
    #1;
    chk("midrst.busy", BUSY, 0);
    chk("midrst.flags", {ALIGN_DONE, ALIGN_FAIL}, 0);
    chk("midrst.pulses", {RX_BIT_SLIP_0, DELAY_LINE_MOVE_0, DELAY_LINE_LOAD_0, DELAY_LINE_DIRECTION_0}, 0);
    chk("midrst.tap", TAP_CNT, 0);
    chk("midrst.rxout", RX_DATA_OUT, 0);
    repeat (2) tick();
    ARST_N = 1'b1;
    tick();
    scen("retrain", 0, 0, 1'b0, 1'b0);

`ifdef DDR3_RX_ALIGN_MONITOR_EN
    chk("mon.err0",  ERR_CNT, 0);
    chk("mon.lost0", LOCK_LOST, 0);
    force_cnt = 20;
    repeat (25) tick();
    chk("mon.err20", ERR_CNT, 20);
    chk("mon.lost",  LOCK_LOST, 1);
    START = 1'b1;
    tick();
    START = 1'b0;
    chk("mon.errclr",  ERR_CNT, 0);
    chk("mon.lostclr", LOCK_LOST, 0);
`endif

    chk("excl", n_multi, 0);
    chk("dir",  n_dir_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
